distortion: RTL and testbench



---
 rtl/distortion.sv | 72 +++++++
 tb/tb_distortion.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/distortion.sv
// Purpose: guitar-pedal distortion, fixed integer pre-gain followed by a symmetric soft-knee clipper.
// Latency: 3 clk rising edges from sin_in to sin_out, with full throughput of one sample per clock.
// Backpressure: none. The stage is free-running and accepts a sample on every clock.
module distortion #(
  parameter int WIDTH = 24,
  parameter int GAIN  = 2,
  parameter int KNEE  = 96,
  parameter int CLIP  = 160
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] sin_in,
  output logic signed [WIDTH-1:0] sin_out
);

  // Eight guard bits are enough for any GAIN up to 255, so the product itself never wraps.
  localparam int PW = WIDTH + 8;
  localparam logic signed [PW-1:0] SAT_POS = PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SAT_NEG = -SAT_POS;
  localparam logic signed [PW-1:0] GAIN_W  = PW'(GAIN);
  localparam logic [WIDTH-1:0] KNEE_W   = WIDTH'(KNEE);
  localparam logic [WIDTH-1:0] CLIP_W   = WIDTH'(CLIP);
  localparam logic [WIDTH-1:0] CLIP_MAG = KNEE_W + ((CLIP_W - KNEE_W) >> 1);

  logic signed [WIDTH-1:0] s1_q;
  logic signed [WIDTH-1:0] s2_q;
  logic signed [PW-1:0]    prod;
  logic signed [WIDTH-1:0] g_sat;
  logic                    neg;
  logic [WIDTH-1:0]        mag_in;
  logic [WIDTH-1:0]        mag_out;
  logic signed [WIDTH-1:0] shaped;

  // Gain stage: widen and multiply, then clamp symmetrically.
  // Clamping the negative side to -(2^(WIDTH-1)-1) also keeps the later abs() from overflowing.
  always_comb begin
    prod  = $signed({{8{s1_q[WIDTH-1]}}, s1_q}) * GAIN_W;
    g_sat = prod[WIDTH-1:0];
    if (prod > SAT_POS) begin
      g_sat = SAT_POS[WIDTH-1:0];
    end else if (prod < SAT_NEG) begin
      g_sat = SAT_NEG[WIDTH-1:0];
    end
  end

  // Shaper: work on the magnitude, then restore the sign so the curve is exactly odd-symmetric.
  always_comb begin
    neg     = s2_q[WIDTH-1];
    mag_in  = neg ? $unsigned(-s2_q) : $unsigned(s2_q);
    mag_out = mag_in;
    if (mag_in >= CLIP_W) begin
      mag_out = CLIP_MAG;
    end else if (mag_in > KNEE_W) begin
      mag_out = KNEE_W + ((mag_in - KNEE_W) >> 1);
    end
    shaped = neg ? -$signed(mag_out) : $signed(mag_out);
  end

  // Three pipeline registers. Reset flushes every in-flight sample at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      sin_out <= '0;
    end else begin
      s1_q    <= sin_in;
      s2_q    <= g_sat;
      sin_out <= shaped;
    end
  end

endmodule

// File: tb/tb_distortion.sv
// Purpose: self-checking bench for distortion using a scoreboard of expected samples.
// Latency: models the 3-edge pipeline with a valid shift register that tracks the DUT.
// Backpressure: none. Stimulus is applied every clock while streaming.
module tb_distortion;
  localparam int WIDTH = 24;
  localparam int GAIN  = 2;
  localparam int KNEE  = 96;
  localparam int CLIP  = 160;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [WIDTH-1:0] sin_in;
  logic signed [WIDTH-1:0] sin_out;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  bit tag_q[$];
  int got_sine[$];
  logic drv_vld;
  logic v1, v2, v3;
  int got_v;
  int exp_v;
  bit tag_v;

  int din[13]  = '{40, -40, 0, 60, -60, 49, 120, -120, 8388607, -8388608, -120, 120, -120};
  int dexp[13] = '{80, -80, 0, 108, -108, 97, 128, -128, 128, -128, -128, 128, -128};
  int samp[64];

  always #4 clk = ~clk;

  distortion #(.WIDTH(WIDTH), .GAIN(GAIN), .KNEE(KNEE), .CLIP(CLIP)) dut (
    .clk    (clk),
    .rst    (rst),
    .sin_in (sin_in),
    .sin_out(sin_out)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Golden model of the transfer curve, written directly from the behavioural description.
  function automatic int model(input int x);
    longint g, a, lim, y;
    lim = (longint'(1) <<< (WIDTH - 1)) - 1;
    g   = longint'(x) * GAIN;
    if (g > lim) g = lim;
    if (g < -lim) g = -lim;
    a = (g < 0) ? -g : g;
    if (a <= KNEE) y = a;
    else if (a < CLIP) y = KNEE + (a - KNEE) / 2;
    else y = KNEE + (CLIP - KNEE) / 2;
    return int'((g < 0) ? -y : y);
  endfunction

  task automatic send(input int x, input int e, input bit tag);
    @(negedge clk);
    sin_in  = WIDTH'(x);
    drv_vld = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Valid tracking that follows the DUT pipeline, including its asynchronous flush.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= drv_vld;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Scoreboard check on the falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (v3) begin
      chk("exp_avail", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag_v = tag_q.pop_front();
        got_v = int'(sin_out);
        chk("stream", got_v, exp_v);
        if (tag_v) got_sine.push_back(got_v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int mx, mn, n128;
    rst     = 1'b0;
    sin_in  = '0;
    drv_vld = 1'b0;

    // Reset held: output stays 0 while the input toggles.
    #1 chk("rst_out", int'(sin_out), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sin_in = WIDTH'($urandom);
      #1 chk("rst_hold", int'(sin_out), 0);
    end
    @(negedge clk);
    sin_in = '0;
    rst    = 1'b1;

    // Stream, then reset mid-stream between clock edges.
    for (int i = 0; i < 6; i++) send(40, 80, 1'b0);
    @(posedge clk);
    #1 chk("pre_rst", int'(sin_out), 80);
    rst = 1'b0;
    #1 chk("async_rst", int'(sin_out), 0);
    drv_vld = 1'b0;
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    chk("rst_mid_hold", int'(sin_out), 0);
    sin_in = 24'sd40;
    @(negedge clk);
    rst = 1'b1;
    sin_in = '0;
    // Flushed samples must not reappear after release.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("flush", int'(sin_out), 0);
    end

    // Directed points, including back-to-back steps at the end.
    for (int i = 0; i < 13; i++) send(din[i], dexp[i], 1'b0);

    // Sine stream, one sample per clock.
    for (int i = 0; i < 32; i++) begin
      samp[i]      = $rtoi(120.0 * $sin(2.0 * 3.14159265358979 * i / 64.0));
      samp[i + 32] = -samp[i];
    end
    for (int i = 0; i < 64; i++) send(samp[i], model(samp[i]), 1'b1);

    @(negedge clk);
    drv_vld = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    chk("sine_cnt", got_sine.size(), 64);
    if (got_sine.size() == 64) begin
      mx = -1000; mn = 1000; n128 = 0;
      for (int i = 0; i < 64; i++) begin
        if (got_sine[i] > mx) mx = got_sine[i];
        if (got_sine[i] < mn) mn = got_sine[i];
        if (got_sine[i] == 128) n128++;
      end
      chk("sine_top", mx, 128);
      chk("sine_bot", mn, -128);
      chk("sine_flat", int'(n128 > 1), 1);
      for (int i = 0; i < 32; i++) chk("sine_sym", got_sine[i], -got_sine[i + 32]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
